ex_muldiv: RTL and testbench

Execute-stage multiply/divide unit with architectural HI/LO registers. It sits directly downstream of the ID/EX pipeline register and consumes the decoded operation and forwarded operands. Multiplies complete in 1 extra cycle; divides run as a 32-iteration restoring divider. While an operation is in flight it asserts `busy`, which the hazard logic uses to freeze PC, IF/ID and ID/EX.

---
 rtl/muldiv_pkg.sv | 30 +++
 rtl/div_core.sv | 59 +++++
 rtl/ex_muldiv.sv | 149 ++++++++++++++
 tb/tb_ex_muldiv.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the execute-stage multiply/divide unit.
// Op codes match the decoder; state enum is private to ex_muldiv.
package muldiv_pkg;

  localparam int XLEN = 32;
  localparam int CNT_W = 5;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_MFHI  = 3'd6,
    OP_MFLO  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } state_e;

  function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/div_core.sv
// Iterative unsigned restoring divider: one quotient bit per clock, 32 clocks after start.
// 'last' is high during the 32nd step; 'kill' abandons the division without touching outputs' meaning.
module div_core
  import muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            kill,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder,
  output logic            last
);

  logic             run_q;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0]  rem_q;
  logic [XLEN-1:0]  quo_q;
  logic [XLEN-1:0]  dvs_q;
  logic [XLEN:0]    shifted;
  logic [XLEN:0]    diff;
  logic             fits;

  // Quotient register doubles as the dividend shift register.
  assign shifted = {rem_q, quo_q[XLEN-1]};
  assign diff    = shifted - {1'b0, dvs_q};
  assign fits    = ~diff[XLEN];
  assign last    = run_q && (cnt_q == CNT_W'(XLEN - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q <= 1'b0;
      cnt_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
    end else if (kill) begin
      run_q <= 1'b0;
      cnt_q <= '0;
    end else if (start) begin
      run_q <= 1'b1;
      cnt_q <= '0;
      rem_q <= '0;
      quo_q <= dividend;
      dvs_q <= divisor;
    end else if (run_q) begin
      rem_q <= fits ? diff[XLEN-1:0] : shifted[XLEN-1:0];
      quo_q <= {quo_q[XLEN-2:0], fits};
      cnt_q <= cnt_q + 1'b1;
      run_q <= ~last;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage mult/div unit with HI/LO: multiply and div-by-zero take 1 extra cycle, divide 33.
// Holds busy while in flight so the hazard unit freezes the front end; flush aborts without writing.
module ex_muldiv
  import muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic            dz,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic [XLEN-1:0] rd_data
);

  state_e state_q, state_d;
  op_e    op_i;

  logic              accept;
  logic              is_mul;
  logic              is_div;
  logic              div_signed;
  logic              b_zero;
  logic              div_start;
  logic              div_last;
  logic              write_mul;
  logic              write_fix;
  logic [2*XLEN-1:0] mul_res;
  logic [2*XLEN-1:0] res_q;
  logic              sign_q_q;
  logic              sign_r_q;
  logic [XLEN-1:0]   a_abs;
  logic [XLEN-1:0]   b_abs;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;

  assign op_i       = op_e'(op);
  assign is_mul     = (op_i == OP_MULT) || (op_i == OP_MULTU);
  assign is_div     = (op_i == OP_DIV) || (op_i == OP_DIVU);
  assign div_signed = (op_i == OP_DIV);
  assign b_zero     = (b == '0);
  assign a_abs      = neg_if(a, div_signed & a[XLEN-1]);
  assign b_abs      = neg_if(b, div_signed & b[XLEN-1]);
  assign div_start  = accept && is_div && !b_zero;

  always_comb begin
    mul_res = '0;
    if (op_i == OP_MULT)
      mul_res = $signed({{XLEN{a[XLEN-1]}}, a}) * $signed({{XLEN{b[XLEN-1]}}, b});
    else
      mul_res = {{XLEN{1'b0}}, a} * {{XLEN{1'b0}}, b};
  end

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    write_mul = 1'b0;
    write_fix = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          accept = 1'b1;
          if (is_mul)
            state_d = S_MUL;
          else if (is_div)
            state_d = b_zero ? S_MUL : S_DIV;
        end
      end
      S_MUL: begin
        state_d   = S_IDLE;
        write_mul = !flush;
      end
      S_DIV: begin
        if (flush)
          state_d = S_IDLE;
        else if (div_last)
          state_d = S_FIX;
      end
      S_FIX: begin
        state_d   = S_IDLE;
        write_fix = !flush;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  div_core u_div_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (div_start),
    .dividend  (a_abs),
    .divisor   (b_abs),
    .kill      (flush),
    .quotient  (quo),
    .remainder (rem),
    .last      (div_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      dz       <= 1'b0;
      res_q    <= '0;
      sign_q_q <= 1'b0;
      sign_r_q <= 1'b0;
    end else begin
      done <= write_mul | write_fix;
      if (accept) begin
        dz <= is_div && b_zero;
        if (is_mul)
          res_q <= mul_res;
        else if (is_div && b_zero)
          res_q <= {a, {XLEN{1'b1}}};
        if (div_start) begin
          sign_q_q <= div_signed & (a[XLEN-1] ^ b[XLEN-1]);
          sign_r_q <= div_signed & a[XLEN-1];
        end
        if (op_i == OP_MTHI)
          hi <= a;
        if (op_i == OP_MTLO)
          lo <= a;
      end
      if (write_mul)
        {hi, lo} <= res_q;
      if (write_fix) begin
        hi <= neg_if(rem, sign_r_q);
        lo <= neg_if(quo, sign_q_q);
      end
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign rd_data = (op_i == OP_MFHI) ? hi : lo;

endmodule

// File: tb/tb_ex_muldiv.sv
// Randomized and directed checks of ex_muldiv against an arithmetic model of HI/LO/dz.
module tb_ex_muldiv;

  localparam logic [2:0] MULT = 3'd0, MULTU = 3'd1, DIV = 3'd2, DIVU = 3'd3,
                         MTHI = 3'd4, MTLO = 3'd5, MFHI = 3'd6, MFLO = 3'd7;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        flush = 1'b0;
  logic        busy, done, dz;
  logic [31:0] hi, lo, rd_data;

  int total = 0;
  int bad = 0;

  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic        m_dz = 1'b0;

  always #5 clk = ~clk;

  ex_muldiv dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b), .flush(flush),
    .busy(busy), .done(done), .dz(dz), .hi(hi), .lo(lo), .rd_data(rd_data)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Architectural effect of one op on HI/LO/dz, straight from the arithmetic definitions.
  task automatic model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       output int exp_busy);
    longint          sx, sy, sq, sr;
    longint unsigned ux, uy;
    logic [63:0]     p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    m_dz = 1'b0;
    exp_busy = 0;
    case (o)
      MULT:  begin p = sx * sy; {m_hi, m_lo} = p; exp_busy = 1; end
      MULTU: begin p = ux * uy; {m_hi, m_lo} = p; exp_busy = 1; end
      DIV, DIVU: begin
        if (y == 0) begin
          m_hi = x; m_lo = 32'hFFFF_FFFF; m_dz = 1'b1; exp_busy = 1;
        end else begin
          if (o == DIV) begin sq = sx / sy; sr = sx % sy; end
          else begin sq = longint'(ux / uy); sr = longint'(ux % uy); end
          m_lo = sq[31:0]; m_hi = sr[31:0]; exp_busy = 33;
        end
      end
      MTHI: m_hi = x;
      MTLO: m_lo = x;
      default: ;
    endcase
  endtask

  // Entered at posedge+1; returns at posedge+1.
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    int exp_busy;
    int nb;
    logic [63:0] exp_rd;
    model(o, x, y, exp_busy);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
    nb = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!busy) break;
      nb++;
    end
    if (nb >= 60) check("busy_timeout", 64'(nb), 64'(exp_busy));
    check("busy_cycles", 64'(nb), 64'(exp_busy));
    check("done", {63'd0, done}, {63'd0, (o <= DIVU)});
    check("hi", {32'd0, hi}, {32'd0, m_hi});
    check("lo", {32'd0, lo}, {32'd0, m_lo});
    check("dz", {63'd0, dz}, {63'd0, m_dz});
    if (o == MFHI || o == MFLO) begin
      exp_rd = {32'd0, (o == MFHI) ? m_hi : m_lo};
      check("rd_data", {32'd0, rd_data}, exp_rd);
    end
    @(posedge clk); #1;
    check("done_pulse", {63'd0, done}, 64'd0);
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] rx, ry;
    int          dummy;

    #12;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_dz", {63'd0, dz}, 64'd0);
    check("rst_hi", {32'd0, hi}, 64'd0);
    check("rst_lo", {32'd0, lo}, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(MULT,  32'hFFFF_FFFD, 32'd5);
    run_op(MULTU, 32'hFFFF_FFFF, 32'd2);
    run_op(DIV,   32'hFFFF_FFF9, 32'd2);
    run_op(DIVU,  32'd100, 32'd7);
    run_op(DIVU,  32'd100, 32'd0);
    run_op(MULT,  32'd6, 32'd7);
    run_op(DIV,   32'h8000_0000, 32'hFFFF_FFFF);
    run_op(DIV,   32'd7, 32'hFFFF_FFFE);
    run_op(MTHI,  32'h1234, 32'd0);
    run_op(MFHI,  32'd0, 32'd0);
    run_op(MTLO,  32'hCAFE_F00D, 32'd0);
    run_op(MFLO,  32'd0, 32'd0);

    // Flush at divide count 10: no write, no done.
    model(MFLO, 32'd0, 32'd0, dummy);
    start = 1'b1; op = DIVU; a = 32'd1000; b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush_busy", {63'd0, busy}, 64'd0);
    check("flush_done", {63'd0, done}, 64'd0);
    check("flush_hi", {32'd0, hi}, {32'd0, m_hi});
    check("flush_lo", {32'd0, lo}, {32'd0, m_lo});
    repeat (40) begin
      @(negedge clk);
      if (done) check("flush_late_done", 64'd1, 64'd0);
    end
    @(posedge clk); #1;

    // Flush beats a simultaneous start: MTHI must not land.
    start = 1'b1; flush = 1'b1; op = MTHI; a = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("flush_start_hi", {32'd0, hi}, {32'd0, m_hi});
    check("flush_start_busy", {63'd0, busy}, 64'd0);
    @(posedge clk); #1;

    // Reset mid-divide at count 20.
    start = 1'b1; op = DIV; a = 32'd12345; b = 32'd17;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    m_hi = '0; m_lo = '0; m_dz = 1'b0;
    check("arst_busy", {63'd0, busy}, 64'd0);
    check("arst_done", {63'd0, done}, 64'd0);
    check("arst_hi", {32'd0, hi}, 64'd0);
    check("arst_lo", {32'd0, lo}, 64'd0);
    check("arst_dz", {63'd0, dz}, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(DIV, 32'd12345, 32'd17);

    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 7));
      rx = $urandom;
      ry = $urandom;
      case ($urandom_range(0, 3))
        0: ry = 32'd0;
        1: ry = ry >> $urandom_range(16, 31);
        default: ;
      endcase
      run_op(ro, rx, ry);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
